ifu_fetch: RTL and testbench

- Instruction fetch stage directly downstream of the PC register unit.
- Takes the current PC and issues one request at a time on the instruction-memory request/response interface.
- Extracts the 32-bit instruction word and presents it to decode with a valid/ready handshake.
- Pulses o_pc_adv back to the PC unit when decode consumes an instruction; supports flush/redirect and reports misaligned or bus-error faults.

---
 rtl/ifu_fetch_if.sv | 31 +++
 rtl/ifu_fetch.sv | 156 +++++++++++++++
 tb/tb_ifu_fetch.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave). One outstanding request at a time.
interface ifu_fetch_if #(
    parameter int unsigned AW = 64,
    parameter int unsigned DW = 64
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [DW-1:0] imem_rdata;
    logic          imem_err;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        input  imem_err
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        output imem_err
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one request in flight, extracts a 32-bit word from a
// 64-bit memory beat and hands it to decode over a valid/ready handshake.
module ifu_fetch #(
    parameter int unsigned AW    = 64,
    parameter int unsigned DW    = 64,
    parameter int unsigned IW    = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    i_pc,
    output logic             o_pc_adv,
    input  logic             i_flush,
    ifu_fetch_if.master      io_imem,
    output logic             o_inst_vld,
    output logic [IW-1:0]    o_inst,
    output logic [AW-1:0]    o_inst_pc,
    output logic [1:0]       o_inst_fault,
    input  logic             i_inst_rdy,
    output logic [CNT_W-1:0] o_fetch_cnt
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

    localparam logic [1:0] FaultNone     = 2'b00;
    localparam logic [1:0] FaultMisalign = 2'b01;
    localparam logic [1:0] FaultBus      = 2'b10;

    state_e           r_state;
    logic             r_drop;
    logic [AW-1:0]    r_fetch_pc;
    logic [IW-1:0]    r_inst;
    logic [AW-1:0]    r_inst_pc;
    logic [1:0]       r_inst_fault;
    logic [CNT_W-1:0] r_fetch_cnt;

    state_e           w_state_nxt;
    logic             w_drop_nxt;
    logic             w_req;
    logic             w_pc_adv;
    logic             w_cnt_inc;
    logic             w_latch_pc;
    logic             w_load;
    logic [IW-1:0]    w_load_inst;
    logic [AW-1:0]    w_load_pc;
    logic [1:0]       w_load_fault;

    always_comb begin
        w_state_nxt  = r_state;
        w_drop_nxt   = r_drop;
        w_req        = 1'b0;
        w_pc_adv     = 1'b0;
        w_cnt_inc    = 1'b0;
        w_latch_pc   = 1'b0;
        w_load       = 1'b0;
        w_load_inst  = '0;
        w_load_pc    = '0;
        w_load_fault = FaultNone;

        unique case (r_state)
            StIdle: w_state_nxt = StReq;

            StReq: begin
                if (i_flush) begin
                    // A grant racing the flush still yields a response that must be eaten.
                    if (io_imem.imem_gnt) begin
                        w_state_nxt = StWait;
                        w_drop_nxt  = 1'b1;
                    end
                end else if (i_pc[1:0] != 2'b00) begin
                    w_load       = 1'b1;
                    w_load_pc    = i_pc;
                    w_load_fault = FaultMisalign;
                    w_state_nxt  = StHold;
                end else begin
                    w_req      = 1'b1;
                    w_latch_pc = 1'b1;
                    if (io_imem.imem_gnt) begin
                        w_state_nxt = StWait;
                        w_drop_nxt  = 1'b0;
                    end
                end
            end

            StWait: begin
                if (io_imem.imem_rvalid) begin
                    if (i_flush || r_drop) begin
                        w_state_nxt = StReq;
                        w_drop_nxt  = 1'b0;
                    end else begin
                        w_load      = 1'b1;
                        w_load_pc   = r_fetch_pc;
                        w_state_nxt = StHold;
                        if (io_imem.imem_err) begin
                            w_load_fault = FaultBus;
                        end else begin
                            w_load_inst = r_fetch_pc[2] ? io_imem.imem_rdata[2*IW-1:IW]
                                                        : io_imem.imem_rdata[IW-1:0];
                        end
                    end
                end else if (i_flush) begin
                    w_drop_nxt = 1'b1;
                end
            end

            StHold: begin
                if (i_flush) begin
                    w_state_nxt = StReq;
                end else if (i_inst_rdy) begin
                    w_pc_adv    = 1'b1;
                    w_cnt_inc   = 1'b1;
                    w_state_nxt = StReq;
                end
            end

            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_drop       <= 1'b0;
            r_fetch_pc   <= '0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_fault <= FaultNone;
            r_fetch_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_drop_nxt;
            if (w_latch_pc) begin
                r_fetch_pc <= i_pc;
            end
            if (w_load) begin
                r_inst       <= w_load_inst;
                r_inst_pc    <= w_load_pc;
                r_inst_fault <= w_load_fault;
            end
            if (w_cnt_inc) begin
                r_fetch_cnt <= r_fetch_cnt + 1'b1;
            end
        end
    end

    assign io_imem.imem_req  = w_req;
    assign io_imem.imem_addr = w_req ? {i_pc[AW-1:3], 3'b000} : '0;

    assign o_pc_adv     = w_pc_adv;
    assign o_inst_vld   = (r_state == StHold);
    assign o_inst       = r_inst;
    assign o_inst_pc    = r_inst_pc;
    assign o_inst_fault = r_inst_fault;
    assign o_fetch_cnt  = r_fetch_cnt;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed vector table, hand-written
// flush/reset sequences and randomized fetches against a spec-level model.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic [63:0] i_pc;
    logic        o_pc_adv;
    logic        i_flush;
    logic        o_inst_vld;
    logic [31:0] o_inst;
    logic [63:0] o_inst_pc;
    logic [1:0]  o_inst_fault;
    logic        i_inst_rdy;
    logic [31:0] o_fetch_cnt;

    ifu_fetch_if #(.AW(64), .DW(64)) u_if ();

    ifu_fetch #(.AW(64), .DW(64), .IW(32), .CNT_W(32)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .i_pc         (i_pc),
        .o_pc_adv     (o_pc_adv),
        .i_flush      (i_flush),
        .io_imem      (u_if),
        .o_inst_vld   (o_inst_vld),
        .o_inst       (o_inst),
        .o_inst_pc    (o_inst_pc),
        .o_inst_fault (o_inst_fault),
        .i_inst_rdy   (i_inst_rdy),
        .o_fetch_cnt  (o_fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] rdata;
        logic        err;
        int          gnt_dly;
        int          rv_dly;
        int          rdy_dly;
        logic [31:0] exp_inst;
        logic [1:0]  exp_fault;
    } vec_t;

    int          n_total;
    int          n_pass;
    logic [31:0] exp_cnt;
    vec_t        vecs[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    // Spec-level model of what decode should see for one fetch.
    function automatic logic [1:0] ref_fault(input logic [63:0] pc, input logic err);
        if (pc[1:0] != 2'b00) return 2'b01;
        if (err) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] ref_inst(input logic [63:0] pc, input logic [63:0] d,
                                             input logic err);
        if (pc[1:0] != 2'b00 || err) return 32'h0;
        return pc[2] ? d[63:32] : d[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts with the DUT in REQ; ends one step after the decode handshake (back in REQ).
    task automatic fetch_one(input vec_t v);
        logic [63:0] exp_addr;
        exp_addr = {v.pc[63:3], 3'b000};
        i_pc = v.pc;
        i_inst_rdy = 1'b0;
        u_if.imem_gnt = 1'b0;
        u_if.imem_rvalid = 1'b0;
        if (v.pc[1:0] == 2'b00) begin
            for (int k = 0; k <= v.gnt_dly; k++) begin
                u_if.imem_gnt = (k == v.gnt_dly);
                @(negedge clk);
                chk("req_high", 64'(u_if.imem_req), 64'd1);
                chk("req_addr", u_if.imem_addr, exp_addr);
                tick();
            end
            u_if.imem_gnt = 1'b0;
            for (int k = 0; k <= v.rv_dly; k++) begin
                u_if.imem_rvalid = (k == v.rv_dly);
                u_if.imem_rdata  = (k == v.rv_dly) ? v.rdata : {$urandom, $urandom};
                u_if.imem_err    = (k == v.rv_dly) ? v.err : 1'($urandom);
                @(negedge clk);
                chk("wait_no_req", 64'(u_if.imem_req), 64'd0);
                chk("wait_no_vld", 64'(o_inst_vld), 64'd0);
                tick();
            end
            u_if.imem_rvalid = 1'b0;
            u_if.imem_err = 1'b0;
        end else begin
            @(negedge clk);
            chk("misal_no_req", 64'(u_if.imem_req), 64'd0);
            tick();
        end
        for (int k = 0; k <= v.rdy_dly; k++) begin
            i_inst_rdy = (k == v.rdy_dly);
            @(negedge clk);
            chk("hold_vld", 64'(o_inst_vld), 64'd1);
            chk("hold_inst", 64'(o_inst), 64'(v.exp_inst));
            chk("hold_pc", o_inst_pc, v.pc);
            chk("hold_fault", 64'(o_inst_fault), 64'(v.exp_fault));
            chk("hold_pc_adv", 64'(o_pc_adv), 64'(k == v.rdy_dly));
            chk("hold_no_req", 64'(u_if.imem_req), 64'd0);
            tick();
        end
        i_inst_rdy = 1'b0;
        exp_cnt++;
        chk("fetch_cnt", 64'(o_fetch_cnt), 64'(exp_cnt));
        chk("post_vld", 64'(o_inst_vld), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        n_total = 0;
        n_pass = 0;
        exp_cnt = 0;
        rst = 1'b1;
        i_pc = 64'h8000_0000;
        i_flush = 1'b0;
        i_inst_rdy = 1'b0;
        u_if.imem_gnt = 1'b0;
        u_if.imem_rvalid = 1'b0;
        u_if.imem_rdata = '0;
        u_if.imem_err = 1'b0;

        vecs[0] = '{64'h8000_0000, 64'h00100093_00000513, 1'b0, 0, 0, 0, 32'h0000_0513, 2'b00};
        vecs[1] = '{64'h8000_0004, 64'h00100093_00000513, 1'b0, 0, 0, 0, 32'h0010_0093, 2'b00};
        vecs[2] = '{64'h8000_0008, 64'hDEADBEEF_CAFEF00D, 1'b0, 0, 0, 5, 32'hCAFE_F00D, 2'b00};
        vecs[3] = '{64'h8000_000C, 64'h11112222_33334444, 1'b0, 3, 4, 0, 32'h1111_2222, 2'b00};
        vecs[4] = '{64'h8000_0002, 64'h55556666_77778888, 1'b0, 0, 0, 1, 32'h0000_0000, 2'b01};
        vecs[5] = '{64'h8000_0010, 64'h12345678_9ABCDEF0, 1'b1, 1, 2, 0, 32'h0000_0000, 2'b10};
        vecs[6] = '{64'h8000_0015, 64'h0, 1'b0, 0, 0, 0, 32'h0000_0000, 2'b01};

        // Reset state
        tick();
        @(negedge clk);
        chk("rst_req", 64'(u_if.imem_req), 64'd0);
        chk("rst_vld", 64'(o_inst_vld), 64'd0);
        chk("rst_pc_adv", 64'(o_pc_adv), 64'd0);
        chk("rst_inst", 64'(o_inst), 64'd0);
        chk("rst_inst_pc", o_inst_pc, 64'd0);
        chk("rst_fault", 64'(o_inst_fault), 64'd0);
        chk("rst_cnt", 64'(o_fetch_cnt), 64'd0);
        do_reset();

        foreach (vecs[i]) fetch_one(vecs[i]);

        // Flush in REQ without grant: re-request with the new PC
        i_pc = 64'h8000_0300;
        i_flush = 1'b1;
        @(negedge clk);
        chk("flush_req_low", 64'(u_if.imem_req), 64'd0);
        tick();
        i_flush = 1'b0;
        fetch_one('{64'h8000_0400, 64'hAAAA0001_BBBB0002, 1'b0, 0, 0, 0, 32'hBBBB_0002, 2'b00});

        // Flush in WAIT with redirect: stale response must vanish
        i_pc = 64'h8000_0040;
        u_if.imem_gnt = 1'b1;
        tick();
        u_if.imem_gnt = 1'b0;
        i_flush = 1'b1;
        i_pc = 64'h8000_0100;
        @(negedge clk);
        chk("flush_wait_req", 64'(u_if.imem_req), 64'd0);
        tick();
        i_flush = 1'b0;
        u_if.imem_rvalid = 1'b1;
        u_if.imem_rdata = 64'hDEAD0000_DEAD0000;
        @(negedge clk);
        chk("flush_wait_vld", 64'(o_inst_vld), 64'd0);
        tick();
        u_if.imem_rvalid = 1'b0;
        @(negedge clk);
        chk("redir_vld", 64'(o_inst_vld), 64'd0);
        chk("redir_pc_adv", 64'(o_pc_adv), 64'd0);
        chk("redir_req", 64'(u_if.imem_req), 64'd1);
        chk("redir_addr", u_if.imem_addr, 64'h8000_0100);
        chk("redir_cnt", 64'(o_fetch_cnt), 64'(exp_cnt));
        tick();
        fetch_one('{64'h8000_0100, 64'hC0DE0001_C0DE0002, 1'b0, 0, 0, 0, 32'hC0DE_0002, 2'b00});

        // Flush in HOLD with simultaneous rdy: flush wins
        i_pc = 64'h8000_0204;
        u_if.imem_gnt = 1'b1;
        tick();
        u_if.imem_gnt = 1'b0;
        u_if.imem_rvalid = 1'b1;
        u_if.imem_rdata = 64'h0BAD0BAD_00000001;
        tick();
        u_if.imem_rvalid = 1'b0;
        i_flush = 1'b1;
        i_inst_rdy = 1'b1;
        @(negedge clk);
        chk("flush_hold_vld", 64'(o_inst_vld), 64'd1);
        chk("flush_hold_inst", 64'(o_inst), 64'h0BAD_0BAD);
        chk("flush_hold_adv", 64'(o_pc_adv), 64'd0);
        tick();
        i_flush = 1'b0;
        i_inst_rdy = 1'b0;
        chk("flush_hold_vld_drop", 64'(o_inst_vld), 64'd0);
        chk("flush_hold_cnt", 64'(o_fetch_cnt), 64'(exp_cnt));

        // Reset during WAIT; late response after reset is ignored
        i_pc = 64'h8000_0500;
        u_if.imem_gnt = 1'b1;
        tick();
        u_if.imem_gnt = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        u_if.imem_rvalid = 1'b1;
        u_if.imem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        chk("wrst_vld", 64'(o_inst_vld), 64'd0);
        chk("wrst_req", 64'(u_if.imem_req), 64'd0);
        chk("wrst_inst", 64'(o_inst), 64'd0);
        chk("wrst_cnt", 64'(o_fetch_cnt), 64'd0);
        tick();
        u_if.imem_rvalid = 1'b0;
        chk("wrst_vld2", 64'(o_inst_vld), 64'd0);
        fetch_one('{64'h8000_0600, 64'h00000001_00000002, 1'b0, 0, 0, 0, 32'h0000_0002, 2'b00});

        // Randomized fetches against the reference model
        for (int n = 0; n < 40; n++) begin
            v.pc = 64'h8000_0000 + 64'($urandom_range(0, 4095)) * 4;
            if ($urandom_range(0, 7) == 0) v.pc[1:0] = 2'($urandom_range(1, 3));
            v.rdata = {$urandom, $urandom};
            v.err = ($urandom_range(0, 5) == 0);
            v.gnt_dly = $urandom_range(0, 3);
            v.rv_dly = $urandom_range(0, 3);
            v.rdy_dly = $urandom_range(0, 3);
            v.exp_inst = ref_inst(v.pc, v.rdata, v.err);
            v.exp_fault = ref_fault(v.pc, v.err);
            fetch_one(v);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
